// File: rtl/fc_layer.sv
// -----------------------------------------------------------------------------
// fc_layer -- fully-connected (dense) stage after the pooling stage.
//
// Computes OUT_LEN neuron outputs from IN_LEN signed fixed-point inputs with a
// single serial multiply-accumulate per cycle:
//   out(o) = sat((bias(o) << FRAC_BITS + sum_i in(i)*weight(o,i)) >>> FRAC_BITS)
// Weights live at address o*IN_LEN+i, biases at OUT_LEN*IN_LEN+o of a small
// coefficient memory that is written through w_wr_en/w_addr/w_data while idle.
// The coefficient memory is deliberately not reset, so coefficients survive a
// reset and a new run can follow without reloading.
//
// Optional build macro: FC_RELU_EN -- when defined, negative saturated results
// are written as 0 (ReLU fused at the output).
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-low reset
//   start      one-cycle run request, honoured only while idle
//   input_fm   IN_LEN flattened signed inputs, element k at [k*DATA_W +: DATA_W]
//   w_wr_en    coefficient write strobe (idle only, in-range address only)
//   w_addr     coefficient address
//   w_data     signed coefficient value
//   busy       high from the cycle after start is accepted until the run ends
//   done       one-cycle pulse when every output has been written
//   output_fm  OUT_LEN flattened signed results, neuron o at [o*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module fc_layer #(
  parameter int IN_LEN    = 9,
  parameter int OUT_LEN   = 4,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 8,
  parameter int ADDR_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [IN_LEN*DATA_W-1:0]   input_fm,
  input  logic                       w_wr_en,
  input  logic [ADDR_W-1:0]          w_addr,
  input  logic [DATA_W-1:0]          w_data,
  output logic                       busy,
  output logic                       done,
  output logic [OUT_LEN*DATA_W-1:0]  output_fm
);

  localparam int NCOEF = OUT_LEN*IN_LEN + OUT_LEN;
  localparam int ACC_W = 2*DATA_W + 4;
  localparam int I_W   = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
  localparam int O_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Clamp an accumulator-width value into the DATA_W signed range.
  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  logic [2:0]               state_r;
  logic [I_W-1:0]           i_r;
  logic [O_W-1:0]           o_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     busy_r;
  logic                     done_r;
  logic signed [DATA_W-1:0] in_r   [IN_LEN];
  logic signed [DATA_W-1:0] out_r  [OUT_LEN];
  logic signed [DATA_W-1:0] coef_r [NCOEF];

  logic [ADDR_W-1:0]          w_idx_s;
  logic [ADDR_W-1:0]          b_idx_s;
  logic signed [DATA_W-1:0]   in_sel_s;
  logic signed [DATA_W-1:0]   w_sel_s;
  logic signed [DATA_W-1:0]   b_sel_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    shift_s;
  logic signed [DATA_W-1:0]   sat_s;
  logic signed [DATA_W-1:0]   res_s;
  logic                       wr_ok_s;

  // Coefficient addressing, the MAC product and the saturated/rectified result.
  always_comb begin
    w_idx_s  = ADDR_W'(o_r) * ADDR_W'(IN_LEN) + ADDR_W'(i_r);
    b_idx_s  = ADDR_W'(OUT_LEN*IN_LEN) + ADDR_W'(o_r);
    in_sel_s = in_r[i_r];
    w_sel_s  = coef_r[w_idx_s];
    b_sel_s  = coef_r[b_idx_s];
    prod_s   = in_sel_s * w_sel_s;
    shift_s  = acc_r >>> FRAC_BITS;
    sat_s    = sat_fn(shift_s);
`ifdef FC_RELU_EN
    if (sat_s[DATA_W-1]) begin
      res_s = {DATA_W{1'b0}};
    end else begin
      res_s = sat_s;
    end
`else
    res_s    = sat_s;
`endif
    wr_ok_s  = w_wr_en && (state_r == ST_IDLE) && (w_addr < ADDR_W'(NCOEF));
  end

  // Coefficient memory: idle-only, in-range writes; intentionally never reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      coef_r[w_addr] <= w_data;
    end
  end

  // Control FSM, input snapshot, accumulator and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      i_r     <= {I_W{1'b0}};
      o_r     <= {O_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      for (int k = 0; k < IN_LEN; k++) begin
        in_r[k] <= {DATA_W{1'b0}};
      end
      for (int k = 0; k < OUT_LEN; k++) begin
        out_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            // Snapshot so input_fm may change freely during the run.
            for (int k = 0; k < IN_LEN; k++) begin
              in_r[k] <= input_fm[k*DATA_W +: DATA_W];
            end
            o_r     <= {O_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_INIT;
          end
        end
        ST_INIT: begin
          acc_r   <= $signed({{(ACC_W-DATA_W){b_sel_s[DATA_W-1]}}, b_sel_s}) <<< FRAC_BITS;
          i_r     <= {I_W{1'b0}};
          state_r <= ST_MAC;
        end
        ST_MAC: begin
          acc_r <= acc_r + $signed({{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s});
          if (i_r == I_W'(IN_LEN-1)) begin
            state_r <= ST_WRITE;
          end else begin
            i_r <= i_r + I_W'(1);
          end
        end
        ST_WRITE: begin
          out_r[o_r] <= res_s;
          if (o_r == O_W'(OUT_LEN-1)) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            o_r     <= o_r + O_W'(1);
            state_r <= ST_INIT;
          end
        end
        ST_DONE: begin
          // start seen here is dropped; it must be re-issued once idle.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;

  for (genvar g = 0; g < OUT_LEN; g++) begin : g_out
    assign output_fm[g*DATA_W +: DATA_W] = out_r[g];
  end

endmodule

// File: tb/tb_fc_layer.sv
// -----------------------------------------------------------------------------
// tb_fc_layer -- self-checking bench for fc_layer.
// A table of {coefficients, inputs, expected outputs} records (directed corner
// values plus random records scored by a plain-arithmetic model) is applied in
// a loop, followed by hand-written multi-cycle sequences: busy protection,
// start during DONE, simultaneous write+start, reset mid-run, back-to-back runs.
// -----------------------------------------------------------------------------
module tb_fc_layer;

  localparam int IN_LEN  = 9;
  localparam int OUT_LEN = 4;
  localparam int DW      = 32;
  localparam int FB      = 8;
  localparam int AW      = 6;
  localparam int LAT     = OUT_LEN*(IN_LEN+2);
  localparam int BUDGET  = 200;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [IN_LEN*DW-1:0]  input_fm;
  logic                  w_wr_en;
  logic [AW-1:0]         w_addr;
  logic [DW-1:0]         w_data;
  logic                  busy;
  logic                  done;
  logic [OUT_LEN*DW-1:0] output_fm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fc_layer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DW), .FRAC_BITS(FB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .input_fm(input_fm),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .output_fm(output_fm)
  );

  typedef struct packed {
    logic [IN_LEN-1:0][DW-1:0]              in_v;
    logic [OUT_LEN-1:0][IN_LEN-1:0][DW-1:0] w_v;
    logic [OUT_LEN-1:0][DW-1:0]             b_v;
    logic [OUT_LEN-1:0][DW-1:0]             exp_v;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input logic [OUT_LEN-1:0][DW-1:0] e, input string tag);
    for (int o = 0; o < OUT_LEN; o++) begin
      chk($sformatf("%s_out%0d", tag, o), 64'(output_fm[o*DW +: DW]), 64'(e[o]));
    end
  endtask

  // Reference: bias scaled into the product format, plus all products, floored
  // back to DW bits, clamped, optionally rectified.
  function automatic logic [OUT_LEN-1:0][DW-1:0] model(input vec_t v);
    logic [OUT_LEN-1:0][DW-1:0] r;
    logic signed [127:0]        a;
    for (int o = 0; o < OUT_LEN; o++) begin
      a = $signed(v.b_v[o]);
      a = a * 256;
      for (int i = 0; i < IN_LEN; i++) begin
        a = a + $signed(v.in_v[i]) * $signed(v.w_v[o][i]);
      end
      a = a >>> FB;
      if (a > 128'sd2147483647) a = 128'sd2147483647;
      else if (a < -128'sd2147483648) a = -128'sd2147483648;
`ifdef FC_RELU_EN
      if (a < 0) a = 0;
`endif
      r[o] = a[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    case ($urandom_range(0, 2))
      0:       return DW'($urandom_range(0, 131071)) - 32'd65536;
      1:       return DW'($urandom());
      default: return DW'($urandom_range(0, 511)) - 32'd256;
    endcase
  endfunction

  task automatic wr(input int a, input logic [DW-1:0] d);
    w_wr_en = 1'b1;
    w_addr  = AW'(a);
    w_data  = d;
    @(negedge clk);
    w_wr_en = 1'b0;
  endtask

  task automatic load_coefs(input vec_t v);
    for (int o = 0; o < OUT_LEN; o++) begin
      for (int i = 0; i < IN_LEN; i++) wr(o*IN_LEN + i, v.w_v[o][i]);
      wr(OUT_LEN*IN_LEN + o, v.b_v[o]);
    end
  endtask

  // Called at a falling edge. inj>=0 pokes start, a weight write and new inputs
  // that many cycles into the run; poke_done re-issues start during DONE.
  task automatic do_run(input logic [IN_LEN*DW-1:0] in_v, input int inj, input bit poke_done,
                        input string tag);
    int lat;
    bit busy_ok;
    input_fm = in_v;
    start    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    w_wr_en = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!done && lat < BUDGET) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == inj) begin
        start    = 1'b1;
        w_wr_en  = 1'b1;
        w_addr   = '0;
        w_data   = '0;
        input_fm = '1;
      end
      @(negedge clk);
      start   = 1'b0;
      w_wr_en = 1'b0;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, "_done_hi"}, 64'(done), 64'd1);
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_lo"}, 64'(done), 64'd0);
    chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
    if (poke_done) begin
      @(negedge clk);
      chk({tag, "_start_in_done_ignored"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    vec_t v;
    logic [OUT_LEN-1:0][DW-1:0] e;
    logic [IN_LEN*DW-1:0] in2;

    rst = 1'b0; start = 1'b0; w_wr_en = 1'b0; w_addr = '0; w_data = '0; input_fm = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_out", 64'(|output_fm), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // identity: weights 1.0, biases 0, inputs 1.0..9.0 -> 45.0
    v = '0;
    for (int k = 0; k < IN_LEN; k++) v.in_v[k] = DW'(256*(k+1));
    for (int o = 0; o < OUT_LEN; o++) begin
      for (int i = 0; i < IN_LEN; i++) v.w_v[o][i] = 32'd256;
      v.exp_v[o] = 32'd11520;
    end
    tbl.push_back(v);
    // bias and sign: weights -1.0, bias(0)=2.0
    for (int o = 0; o < OUT_LEN; o++) for (int i = 0; i < IN_LEN; i++) v.w_v[o][i] = 32'hFFFF_FF00;
    v.b_v[0] = 32'd512;
`ifdef FC_RELU_EN
    v.exp_v = '0;
`else
    v.exp_v[0] = -32'sd11008;
    for (int o = 1; o < OUT_LEN; o++) v.exp_v[o] = -32'sd11520;
`endif
    tbl.push_back(v);
    // positive saturation
    v = '0;
    for (int k = 0; k < IN_LEN; k++) v.in_v[k] = 32'h7FFF_FFFF;
    for (int o = 0; o < OUT_LEN; o++) begin
      for (int i = 0; i < IN_LEN; i++) v.w_v[o][i] = 32'h7FFF_FFFF;
      v.exp_v[o] = 32'h7FFF_FFFF;
    end
    tbl.push_back(v);
    // negative saturation
    for (int o = 0; o < OUT_LEN; o++) begin
      for (int i = 0; i < IN_LEN; i++) v.w_v[o][i] = 32'h8000_0000;
`ifdef FC_RELU_EN
      v.exp_v[o] = 32'h0;
`else
      v.exp_v[o] = 32'h8000_0000;
`endif
    end
    tbl.push_back(v);
    // truncation toward -inf: 1 * -1 raw -> -1/256 floors to -1
    v = '0;
    v.in_v[0]    = 32'd1;
    v.w_v[0][0]  = 32'hFFFF_FFFF;
`ifdef FC_RELU_EN
    v.exp_v[0]   = 32'h0;
`else
    v.exp_v[0]   = 32'hFFFF_FFFF;
`endif
    tbl.push_back(v);
    // random records scored by the model
    for (int n = 0; n < 6; n++) begin
      v = '0;
      for (int k = 0; k < IN_LEN; k++) v.in_v[k] = rnd();
      for (int o = 0; o < OUT_LEN; o++) begin
        for (int i = 0; i < IN_LEN; i++) v.w_v[o][i] = rnd();
        v.b_v[o] = rnd();
      end
      v.exp_v = model(v);
      tbl.push_back(v);
    end

    foreach (tbl[n]) begin
      load_coefs(tbl[n]);
      do_run(tbl[n].in_v, -1, 1'b0, $sformatf("vec%0d", n));
      chk_outs(tbl[n].exp_v, $sformatf("vec%0d", n));
    end

    // busy protection: mid-run start, weight write and input change are dropped
    for (int o = 0; o < OUT_LEN; o++) e[o] = 32'd11520;
    load_coefs(tbl[0]);
    do_run(tbl[0].in_v, 10, 1'b0, "busyprot");
    chk_outs(e, "busyprot");
    do_run(tbl[0].in_v, -1, 1'b1, "retained");
    chk_outs(e, "retained");

    // write and start in the same idle cycle; out-of-range writes ignored
    wr(0, 32'd0);
    wr(40, 32'h0001_2345);
    wr(63, 32'h0001_2345);
    w_wr_en = 1'b1; w_addr = '0; w_data = 32'd256;
    do_run(tbl[0].in_v, -1, 1'b0, "wr_start");
    chk_outs(e, "wr_start");

    // reset mid-run
    input_fm = tbl[0].in_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out", 64'(|output_fm), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_run(tbl[0].in_v, -1, 1'b0, "after_rst");
    chk_outs(e, "after_rst");

    // back-to-back: second start in the first idle cycle, inputs doubled
    for (int k = 0; k < IN_LEN; k++) in2[k*DW +: DW] = DW'(512*(k+1));
    do_run(tbl[0].in_v, -1, 1'b0, "b2b_first");
    do_run(in2, -1, 1'b0, "b2b_second");
    for (int o = 0; o < OUT_LEN; o++) e[o] = 32'd23040;
    chk_outs(e, "b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
